// File: rtl/wash_ctrl_param.sv
// Washing-machine sequencer: FILL, then WASH/RINSE repeated, SPIN, DONE.
// Phase timing comes from a shared prescaler tick and a per-phase tick counter.
module wash_ctrl_param #(
   parameter int TICK_DIV = 1000000,
   parameter int FILL_T   = 2,
   parameter int WASH_T   = 5,
   parameter int RINSE_T  = 2,
   parameter int SPIN_T   = 1,
   parameter int MAX_REPS = 3,
   parameter int REP_W    = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             coin_in,
   input  logic [REP_W-1:0] reps_in,
   input  logic             timer_pause,
   output logic [2:0]       phase,
   output logic [REP_W-1:0] rep_idx,
   output logic             fill_valve,
   output logic             motor_on,
   output logic             drain_valve,
   output logic             wash_done
);

   localparam int MAXD_A = (FILL_T > WASH_T) ? FILL_T : WASH_T;
   localparam int MAXD_B = (RINSE_T > SPIN_T) ? RINSE_T : SPIN_T;
   localparam int MAXD   = (MAXD_A > MAXD_B) ? MAXD_A : MAXD_B;
   localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PC_W   = (MAXD > 1) ? $clog2(MAXD) : 1;
   localparam int RP_W   = (MAX_REPS > 1) ? $clog2(MAX_REPS + 1) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_WASH  = 3'd2,
      S_RINSE = 3'd3,
      S_SPIN  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           r_state;
   logic [PRE_W-1:0] r_pre;
   logic [PC_W-1:0]  r_pc;
   logic [REP_W-1:0] r_rep_idx;
   logic [RP_W-1:0]  r_reps;
   logic             r_fill;
   logic             r_motor;
   logic             r_drain;
   logic             r_done;

   state_t           w_nxt;
   logic [REP_W-1:0] w_rep_nxt;
   logic [PC_W-1:0]  w_dur_last;
   logic [RP_W-1:0]  w_clamp;
   logic             w_run;
   logic             w_hold;
   logic             w_adv;
   logic             w_tick;
   logic             w_end;
   logic             w_more;

   assign w_run  = (r_state == S_FILL) || (r_state == S_WASH) ||
                   (r_state == S_RINSE) || (r_state == S_SPIN);
   assign w_hold = (r_state == S_SPIN) && timer_pause;
   assign w_adv  = w_run && !w_hold;
   assign w_tick = w_adv && (r_pre == PRE_LAST);
   assign w_end  = w_tick && (r_pc == w_dur_last);
   assign w_more = (32'(r_rep_idx) + 32'd1) < 32'(r_reps);

   // Zero requests still run one wash; oversized requests saturate.
   always_comb begin
      w_clamp = RP_W'(reps_in);
      if (reps_in == '0)
         w_clamp = RP_W'(1);
      else if (32'(reps_in) > 32'(MAX_REPS))
         w_clamp = RP_W'(MAX_REPS);
   end

   always_comb begin
      w_nxt      = r_state;
      w_rep_nxt  = r_rep_idx;
      w_dur_last = '0;
      unique case (r_state)
         S_IDLE: begin
            if (coin_in) begin
               w_nxt     = S_FILL;
               w_rep_nxt = '0;
            end
         end
         S_FILL: begin
            w_dur_last = PC_W'(FILL_T - 1);
            if (w_end) w_nxt = S_WASH;
         end
         S_WASH: begin
            w_dur_last = PC_W'(WASH_T - 1);
            if (w_end) w_nxt = S_RINSE;
         end
         S_RINSE: begin
            w_dur_last = PC_W'(RINSE_T - 1);
            if (w_end) begin
               if (w_more) begin
                  w_nxt     = S_WASH;
                  w_rep_nxt = r_rep_idx + REP_W'(1);
               end else begin
                  w_nxt = S_SPIN;
               end
            end
         end
         S_SPIN: begin
            w_dur_last = PC_W'(SPIN_T - 1);
            if (w_end) w_nxt = S_DONE;
         end
         S_DONE: begin
            if (!coin_in) w_nxt = S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pre     <= '0;
         r_pc      <= '0;
         r_rep_idx <= '0;
         r_reps    <= RP_W'(1);
         r_fill    <= 1'b0;
         r_motor   <= 1'b0;
         r_drain   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_nxt;
         r_rep_idx <= w_rep_nxt;
         if ((r_state == S_IDLE) && coin_in)
            r_reps <= w_clamp;
         if (w_nxt != r_state) begin
            r_pre <= '0;
            r_pc  <= '0;
         end else if (w_adv) begin
            if (w_tick) begin
               r_pre <= '0;
               r_pc  <= r_pc + PC_W'(1);
            end else begin
               r_pre <= r_pre + PRE_W'(1);
            end
         end
         r_fill  <= (w_nxt == S_FILL);
         r_motor <= (w_nxt == S_WASH) || (w_nxt == S_RINSE) ||
                    ((w_nxt == S_SPIN) && !w_hold);
         r_drain <= (w_nxt == S_RINSE) || (w_nxt == S_SPIN);
         r_done  <= (w_nxt == S_DONE);
      end
   end

   assign phase       = r_state;
   assign rep_idx     = r_rep_idx;
   assign fill_valve  = r_fill;
   assign motor_on    = r_motor;
   assign drain_valve = r_drain;
   assign wash_done   = r_done;

endmodule

// File: tb/tb_wash_ctrl_param.sv
// Bench for wash_ctrl_param: expected phase entries are queued by the
// stimulus and checked by a monitor whenever the phase output changes.
module tb_wash_ctrl_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       coin_in = 1'b0;
   logic [1:0] reps_in = 2'd0;
   logic       timer_pause = 1'b0;
   logic [2:0] phase;
   logic [1:0] rep_idx;
   logic       fill_valve;
   logic       motor_on;
   logic       drain_valve;
   logic       wash_done;

   wash_ctrl_param #(
      .TICK_DIV(4), .FILL_T(2), .WASH_T(5), .RINSE_T(2),
      .SPIN_T(1), .MAX_REPS(3), .REP_W(2)
   ) dut (
      .clk(clk), .rst(rst), .coin_in(coin_in), .reps_in(reps_in),
      .timer_pause(timer_pause), .phase(phase), .rep_idx(rep_idx),
      .fill_valve(fill_valve), .motor_on(motor_on),
      .drain_valve(drain_valve), .wash_done(wash_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ph;
      int         rep;
      logic [3:0] outs;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   logic [2:0] prev_ph = 3'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && (phase !== prev_ph)) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_phase at cycle %0d: got %0d expected none",
                     cyc, phase);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("phase", int'(phase), e.ph);
            chk("phase_cycle", cyc, e.cyc);
            if (e.rep >= 0) chk("rep_idx", int'(rep_idx), e.rep);
            chk("outputs", int'({fill_valve, motor_on, drain_valve, wash_done}),
                int'(e.outs));
         end
         prev_ph = phase;
      end
   end

   task automatic push(int ph, int rep, logic [3:0] outs, int t);
      exp_t e;
      e.ph = ph; e.rep = rep; e.outs = outs; e.cyc = t;
      q.push_back(e);
   endtask

   // Full run expectations relative to base (the edge before FILL entry).
   task automatic push_run(int base, int reps, int spin_extra);
      int t;
      t = base + 1;
      push(1, 0, 4'b1000, t);
      t += 8;
      for (int r = 0; r < reps; r++) begin
         push(2, r, 4'b0100, t);
         t += 20;
         push(3, r, 4'b0110, t);
         t += 8;
      end
      push(4, reps - 1, 4'b0110, t);
      t += 4 + spin_extra;
      push(5, reps - 1, 4'b0001, t);
   endtask

   task automatic wait_until(int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wait_drain(string nm, int limit);
      int n = 0;
      while (q.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d expected phases still pending, required 0",
                  nm, q.size());
         q.delete();
      end
   endtask

   task automatic finish_run(string nm);
      int m;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({nm, "_done_hold"}, int'(wash_done), 1);
      end
      m = cyc;
      push(0, -1, 4'b0000, m + 1);
      coin_in = 1'b0;
      wait_drain({nm, "_idle"}, 10);
      @(negedge clk);
      chk({nm, "_idle_phase"}, int'(phase), 0);
   endtask

   task automatic run(string nm, logic [1:0] req, int eff);
      int base;
      @(negedge clk);
      base = cyc;
      push_run(base, eff, 0);
      reps_in = req;
      coin_in = 1'b1;
      wait_drain(nm, 200);
      finish_run(nm);
   endtask

   initial begin
      int base;
      int base2;
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
      base = 0; base2 = 0;
   end

   initial begin
      int base;
      int base2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_phase", int'(phase), 0);
      chk("reset_rep", int'(rep_idx), 0);
      chk("reset_outs", int'({fill_valve, motor_on, drain_valve, wash_done}), 0);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_coin", int'(phase), 0);

      run("single", 2'd1, 1);
      run("double", 2'd2, 2);
      run("zero_reps", 2'd0, 1);
      run("triple", 2'd3, 3);

      // Pause held through WASH (ignored) and 3 cycles mid-SPIN.
      @(negedge clk);
      base = cyc;
      push_run(base, 2, 3);
      reps_in = 2'd2;
      coin_in = 1'b1;
      wait_until(base + 8);
      timer_pause = 1'b1;
      wait_until(base + 15);
      chk("wash_pause_motor", int'(motor_on), 1);
      wait_until(base + 28);
      timer_pause = 1'b0;
      wait_until(base + 66);
      chk("spin_motor_before", int'(motor_on), 1);
      timer_pause = 1'b1;
      for (int i = 67; i <= 69; i++) begin
         wait_until(base + i);
         chk("spin_paused_motor", int'(motor_on), 0);
         chk("spin_paused_drain", int'(drain_valve), 1);
         chk("spin_paused_phase", int'(phase), 4);
      end
      timer_pause = 1'b0;
      wait_until(base + 70);
      chk("spin_motor_after", int'(motor_on), 1);
      wait_drain("pause", 100);
      finish_run("pause");

      // Reset in WASH cycle 10, coin held so the run restarts at once.
      @(negedge clk);
      base = cyc;
      reps_in = 2'd1;
      push(1, 0, 4'b1000, base + 1);
      push(2, 0, 4'b0100, base + 9);
      push(0, 0, 4'b0000, base + 19);
      coin_in = 1'b1;
      wait_until(base + 18);
      rst = 1'b1;
      wait_until(base + 19);
      chk("rst_phase", int'(phase), 0);
      chk("rst_outs", int'({fill_valve, motor_on, drain_valve, wash_done}), 0);
      base2 = cyc;
      push_run(base2, 1, 0);
      rst = 1'b0;
      wait_drain("restart", 100);
      finish_run("restart");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
